// File: rtl/md_unit_param.sv
// md_unit_param: HI/LO multiply/divide unit for the EX stage.
// Multiply-class ops finish after MULT_LAT busy cycles; divide is a
// WIDTH-step restoring divider followed by one sign-fixup cycle.
module md_unit_param #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MULT_LAT > WIDTH) ? MULT_LAT : WIDTH;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV_ITER, DIV_FIX} state_t;
  typedef enum logic [1:0] {ACC_SET, ACC_ADD, ACC_SUB} acc_t;

  state_t state, state_next;
  acc_t   acc_mode;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod, prod_c, ext_a, ext_b, acc_res;
  logic [WIDTH-1:0]   quo, rem, dvs, q_fix, r_fix, a_abs, b_abs;
  logic [WIDTH:0]     trial, diff;
  logic               q_neg, r_neg;
  logic               is_mul, is_div, mul_signed, div_signed;

  assign busy = (state != IDLE);

  // Decode the op and form the acceptance-time operands
  always_comb begin
    is_mul     = op inside {4'd1, 4'd2, 4'd7, 4'd8, 4'd9, 4'd10};
    mul_signed = op inside {4'd1, 4'd7, 4'd9};
    is_div     = (op == 4'd3) || (op == 4'd4);
    div_signed = (op == 4'd3);
    start      = (is_mul || is_div) && (state == IDLE) && !flush;
    ext_a      = mul_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    ext_b      = mul_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    prod_c     = ext_a * ext_b;
    a_abs      = (div_signed && a[WIDTH-1]) ? ('0 - a) : a;
    b_abs      = (div_signed && b[WIDTH-1]) ? ('0 - b) : b;
  end

  // Restoring-divide step, sign fixup and accumulate result
  always_comb begin
    trial   = {rem, quo[WIDTH-1]};
    diff    = trial - {1'b0, dvs};
    q_fix   = q_neg ? ('0 - quo) : quo;
    r_fix   = r_neg ? ('0 - rem) : rem;
    acc_res = prod;
    case (acc_mode)
      ACC_ADD: acc_res = {hi, lo} + prod;
      ACC_SUB: acc_res = {hi, lo} - prod;
      default: acc_res = prod;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; flush always returns to IDLE
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:     if (start) state_next = is_div ? DIV_ITER : MUL;
        MUL:      if (cnt == '0) state_next = IDLE;
        DIV_ITER: if (cnt == '0) state_next = DIV_FIX;
        DIV_FIX:  state_next = IDLE;
        default:  state_next = IDLE;
      endcase
    end
  end

  // Datapath: operand latches, divider registers, counter and HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      prod     <= '0;
      acc_mode <= ACC_SET;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
    end else if (!flush) begin
      case (state)
        IDLE: begin
          if (is_mul) begin
            prod <= prod_c;
            cnt  <= CW'(MULT_LAT - 1);
            if (op inside {4'd7, 4'd8})       acc_mode <= ACC_ADD;
            else if (op inside {4'd9, 4'd10}) acc_mode <= ACC_SUB;
            else                              acc_mode <= ACC_SET;
          end else if (is_div) begin
            quo   <= a_abs;
            rem   <= '0;
            dvs   <= b_abs;
            q_neg <= div_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg <= div_signed && a[WIDTH-1];
            cnt   <= CW'(WIDTH - 1);
          end else if (op == 4'd5) begin
            hi <= a;
          end else if (op == 4'd6) begin
            lo <= a;
          end
        end
        MUL: begin
          if (cnt == '0) {hi, lo} <= acc_res;
          else           cnt <= cnt - 1'b1;
        end
        DIV_ITER: begin
          // quo doubles as the dividend shifter: its MSB feeds the trial
          // remainder while quotient bits enter at the LSB.
          if (!diff[WIDTH]) begin
            rem <= diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        DIV_FIX: begin
          // A zero divisor leaves rem = |a| (restoring to a via r_neg) but
          // the sign fixup would corrupt the all-ones quotient, so force it.
          lo <= (dvs == '0) ? '1 : q_fix;
          hi <= r_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit_param.sv
// Directed bench for md_unit_param: 32-bit/5-cycle and 8-bit/1-cycle builds.
module tb_md_unit_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op32, op8;
  logic [31:0] a32, b32;
  logic [7:0]  a8, b8;
  logic        flush32, flush8;
  logic        start32, busy32, start8, busy8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;

  int tests = 0;
  int fails = 0;
  int cyc;

  always #5 clk = ~clk;

  md_unit_param #(.WIDTH(32), .MULT_LAT(5)) dut32 (
    .clk(clk), .reset(reset), .op(op32), .a(a32), .b(b32), .flush(flush32),
    .start(start32), .busy(busy32), .hi(hi32), .lo(lo32)
  );

  md_unit_param #(.WIDTH(8), .MULT_LAT(1)) dut8 (
    .clk(clk), .reset(reset), .op(op8), .a(a8), .b(b8), .flush(flush8),
    .start(start8), .busy(busy8), .hi(hi8), .lo(lo8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op on the 32-bit unit and count busy cycles until it drops
  task automatic op32_run(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int n);
    @(negedge clk);
    op32 = o; a32 = x; b32 = y;
    @(posedge clk);
    #1 op32 = 4'd0;
    n = 0;
    while (busy32 && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  task automatic op8_run(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                         output int n);
    @(negedge clk);
    op8 = o; a8 = x; b8 = y;
    @(posedge clk);
    #1 op8 = 4'd0;
    n = 0;
    while (busy8 && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  initial begin
    reset = 1'b1;
    op32 = '0; a32 = '0; b32 = '0; flush32 = 1'b0;
    op8 = '0;  a8 = '0;  b8 = '0;  flush8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Asynchronous reset in the middle of a divide
    op32_run(4'd5, 32'h0000_1234, 32'h0, cyc);
    check("mthi_pre", hi32, 32'h0000_1234);
    @(negedge clk);
    op32 = 4'd3; a32 = 32'd100; b32 = 32'd3;
    @(posedge clk);
    #1 op32 = 4'd0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("rst_busy", busy32, 0);
    check("rst_hi", hi32, 0);
    check("rst_lo", lo32, 0);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", busy32, 0);
    check("idle_hi", hi32, 0);

    // start is combinational
    @(negedge clk);
    op32 = 4'd1;
    #1 check("start_comb", start32, 1);
    flush32 = 1'b1;
    #1 check("start_flush", start32, 0);
    flush32 = 1'b0; op32 = 4'd0;

    // Multiply
    op32_run(4'd1, 32'hFFFF_FFFE, 32'd3, cyc);
    check("mult_cyc", cyc, 5);
    check("mult_hi", hi32, 32'hFFFF_FFFF);
    check("mult_lo", lo32, 32'hFFFF_FFFA);
    op32_run(4'd2, 32'hFFFF_FFFE, 32'd3, cyc);
    check("multu_cyc", cyc, 5);
    check("multu_hi", hi32, 32'h0000_0002);
    check("multu_lo", lo32, 32'hFFFF_FFFA);

    // Accumulate
    op32_run(4'd5, 32'd1, 32'd0, cyc);
    check("mthi_cyc", cyc, 0);
    op32_run(4'd6, 32'hFFFF_FFFF, 32'd0, cyc);
    op32_run(4'd7, 32'd1, 32'd1, cyc);
    check("madd_hi", hi32, 32'd2);
    check("madd_lo", lo32, 32'd0);
    op32_run(4'd10, 32'd2, 32'd1, cyc);
    check("msubu_hi", hi32, 32'd1);
    check("msubu_lo", lo32, 32'hFFFF_FFFE);

    // Divide
    op32_run(4'd3, 32'hFFFF_FFF9, 32'd2, cyc);
    check("div_cyc", cyc, 33);
    check("div_lo", lo32, 32'hFFFF_FFFD);
    check("div_hi", hi32, 32'hFFFF_FFFF);
    op32_run(4'd4, 32'd7, 32'd0, cyc);
    check("divu0_lo", lo32, 32'hFFFF_FFFF);
    check("divu0_hi", hi32, 32'd7);
    op32_run(4'd3, 32'hFFFF_FFFB, 32'd0, cyc);
    check("div0_lo", lo32, 32'hFFFF_FFFF);
    check("div0_hi", hi32, 32'hFFFF_FFFB);
    op32_run(4'd4, 32'd100, 32'd7, cyc);
    check("divu_lo", lo32, 32'd14);
    check("divu_hi", hi32, 32'd2);
    op32_run(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    check("divovf_lo", lo32, 32'h8000_0000);
    check("divovf_hi", hi32, 32'd0);

    // Flush mid-divide, with an mthi attempted while busy
    @(negedge clk);
    op32 = 4'd3; a32 = 32'd100; b32 = 32'd7;
    @(posedge clk);
    #1 op32 = 4'd0;
    repeat (5) @(negedge clk);
    op32 = 4'd5; a32 = 32'hDEAD_BEEF;
    #1 check("start_busy", start32, 0);
    @(posedge clk);
    #1 op32 = 4'd0;
    check("mthi_busy_hi", hi32, 32'd0);
    repeat (4) @(negedge clk);
    flush32 = 1'b1;
    @(posedge clk);
    #1 flush32 = 1'b0;
    check("flush_busy", busy32, 0);
    repeat (40) @(posedge clk);
    #1;
    check("flush_hi", hi32, 32'd0);
    check("flush_lo", lo32, 32'h8000_0000);

    // Flush coinciding with the multiply completion edge
    @(negedge clk);
    op32 = 4'd1; a32 = 32'd5; b32 = 32'd5;
    @(posedge clk);
    #1 op32 = 4'd0;
    repeat (5) @(negedge clk);
    flush32 = 1'b1;
    @(posedge clk);
    #1 flush32 = 1'b0;
    check("flushend_busy", busy32, 0);
    check("flushend_lo", lo32, 32'h8000_0000);
    check("flushend_hi", hi32, 32'd0);

    // Flush suppresses mtlo
    @(negedge clk);
    op32 = 4'd6; a32 = 32'h1111_2222; flush32 = 1'b1;
    @(posedge clk);
    #1 op32 = 4'd0; flush32 = 1'b0;
    check("flush_mtlo", lo32, 32'h8000_0000);

    // Back-to-back: next op accepted on first idle cycle
    op32_run(4'd2, 32'd6, 32'd7, cyc);
    op32_run(4'd8, 32'd2, 32'd3, cyc);
    check("b2b_lo", lo32, 32'd48);
    check("b2b_hi", hi32, 32'd0);

    // 8-bit, single-cycle multiply build
    op8_run(4'd1, 8'h80, 8'h80, cyc);
    check("m8_cyc", cyc, 1);
    check("m8_hi", hi8, 8'h40);
    check("m8_lo", lo8, 8'h00);
    op8_run(4'd4, 8'd200, 8'd7, cyc);
    check("d8_cyc", cyc, 9);
    check("d8_lo", lo8, 8'd28);
    check("d8_hi", hi8, 8'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
